// File: rtl/icb_types.sv
// Shared ICB bus types used by the loaders and by the SRAM responder.
package icb_types;

  localparam logic [1:0] ICB_SIZE_WORD = 2'b10;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic        read;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [1:0]  size;
  } icb_cmd_m_t;

  typedef struct packed {
    logic ready;
  } icb_cmd_s_t;

  typedef struct packed {
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
  } icb_rsp_s_t;

  typedef struct packed {
    logic rsp_ready;
  } icb_rsp_m_t;

endpackage

// File: rtl/icb_rsp_fifo.sv
// Synchronous circular FIFO holding queued response data for the ICB SRAM responder.
module icb_rsp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [CNT_W-1:0] r_cnt;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= nxt(r_wp);
      if (i_pop)  r_rp <= nxt(r_rp);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/icb_sram_slave.sv
// ICB responder in front of a word-addressed single-port SRAM with a credit-managed response FIFO.
// Optional byte-lane write masking is enabled by defining ICB_SRAM_SLV_WMASK_EN.
module icb_sram_slave
  import icb_types::*;
#(
  parameter int          DEPTH     = 256,
  parameter int          BUS_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RSP_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  icb_cmd_m_t icb_cmd_m,
  output icb_cmd_s_t icb_cmd_s,
  output icb_rsp_s_t icb_rsp_s,
  input  icb_rsp_m_t icb_rsp_m,
  output logic       busy_o
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic [BUS_WIDTH-1:0] r_mem [DEPTH];
  logic [BUS_WIDTH-1:0] r_rdata;
  logic                 r_inflight;

  logic [32:0]          w_addr, w_base, w_top;
  logic [31:0]          w_off;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_in_range, w_fire, w_ready;
  logic                 w_push, w_pop, w_empty;
  logic [BUS_WIDTH-1:0] w_head;
  logic [CNT_W-1:0]     w_cnt;
  logic                 w_unused;

  assign w_addr     = {1'b0, icb_cmd_m.addr};
  assign w_base     = {1'b0, BASE_ADDR};
  assign w_top      = w_base + (33'(DEPTH) << 2);
  assign w_in_range = (w_addr >= w_base) && (w_addr < w_top);
  assign w_off      = icb_cmd_m.addr - BASE_ADDR;
  assign w_idx      = w_off[IDX_W+1:2];

  // One credit per FIFO slot; the in-flight response already owns one.
  assign w_ready = !rst &&
                   (({1'b0, w_cnt} + (CNT_W+1)'(r_inflight)) < (CNT_W+1)'(RSP_DEPTH));
  assign w_fire  = icb_cmd_m.valid && w_ready;
  assign icb_cmd_s.ready = w_ready;

  always_ff @(posedge clk) begin
    if (w_fire && !icb_cmd_m.read && w_in_range) begin
`ifdef ICB_SRAM_SLV_WMASK_EN
      for (int b = 0; b < BUS_WIDTH/8; b++)
        if (icb_cmd_m.wmask[b]) r_mem[w_idx][8*b +: 8] <= icb_cmd_m.wdata[8*b +: 8];
`else
      r_mem[w_idx] <= icb_cmd_m.wdata;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_inflight <= w_fire;
      if (w_fire) r_rdata <= (icb_cmd_m.read && w_in_range) ? r_mem[w_idx] : '0;
    end
  end

  // An in-flight response bypasses an empty FIFO so it can be taken at fire+1.
  assign w_pop  = !w_empty && icb_rsp_m.rsp_ready;
  assign w_push = r_inflight && !(w_empty && icb_rsp_m.rsp_ready);

  icb_rsp_fifo #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (RSP_DEPTH),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (r_rdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_cnt),
    .o_empty (w_empty)
  );

  assign icb_rsp_s.rsp_valid = !w_empty || r_inflight;
  assign icb_rsp_s.rsp_rdata = !w_empty ? w_head : (r_inflight ? r_rdata : '0);
  assign busy_o              = r_inflight || !w_empty;

`ifdef ICB_SRAM_SLV_WMASK_EN
  assign w_unused = ^{icb_cmd_m.size, w_off[1:0], w_off[31:IDX_W+2]};
`else
  assign w_unused = ^{icb_cmd_m.size, icb_cmd_m.wmask, w_off[1:0], w_off[31:IDX_W+2]};
`endif

endmodule

// File: tb/tb_icb_sram_slave.sv
// Randomized scoreboard bench for icb_sram_slave against a word-array reference model.
module tb_icb_sram_slave;
  import icb_types::*;

  localparam int          DEPTH     = 256;
  localparam logic [31:0] BASE      = 32'h1000_0000;
  localparam int          RSP_DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  icb_cmd_m_t cmd;
  icb_cmd_s_t cmd_s;
  icb_rsp_s_t rsp;
  icb_rsp_m_t rsp_m;
  logic       busy;

  always #5 clk = ~clk;

  icb_sram_slave #(
    .DEPTH(DEPTH), .BUS_WIDTH(32), .BASE_ADDR(BASE), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .icb_cmd_m(cmd), .icb_cmd_s(cmd_s),
    .icb_rsp_s(rsp), .icb_rsp_m(rsp_m), .busy_o(busy)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q [$];
  logic [31:0] model [DEPTH];
  bit          rand_rdy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a plain word array; out-of-range reads give 0, writes respond 0.
  function automatic logic [31:0] model_step(input logic rd, input logic [31:0] addr,
                                             input logic [31:0] wd, input logic [3:0] wm);
    longint a   = longint'(addr);
    longint b   = longint'(BASE);
    bit     inr = (a >= b) && (a < b + 4*DEPTH);
    int     idx = int'((a - b) / 4);
    if (rd) return inr ? model[idx] : 32'h0;
    if (inr) begin
`ifdef ICB_SRAM_SLV_WMASK_EN
      for (int k = 0; k < 4; k++)
        if (wm[k]) model[idx][8*k +: 8] = wd[8*k +: 8];
`else
      model[idx] = wd;
`endif
    end
    return 32'h0;
  endfunction

  task automatic issue(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] wm, output int waits);
    bit ok = 0;
    waits = 0;
    cmd = '{valid: 1'b1, addr: addr, read: rd, wdata: wd, wmask: wm, size: ICB_SIZE_WORD};
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_s.ready) begin
        exp_q.push_back(model_step(rd, addr, wd, wm));
        ok = 1;
      end else waits++;
      @(posedge clk); #1;
    end
    cmd.valid = 1'b0;
    if (!ok) chk("issue_ready_timeout", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_rdy) rsp_m.rsp_ready = ($urandom % 4) != 0;
  end

  always @(negedge clk) begin
    if (!rst && rsp.rsp_valid) begin
      if (exp_q.size() == 0) chk("unexpected_rsp_valid", 32'(rsp.rsp_valid), 32'd0);
      else if (rsp_m.rsp_ready) chk("rsp_rdata", rsp.rsp_rdata, exp_q.pop_front());
      else chk("rsp_hold_stable", rsp.rsp_rdata, exp_q[0]);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int w, acc;
    logic [31:0] a;
    cmd = '0;
    rsp_m.rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(cmd_s.ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp.rsp_valid), 32'd0);
    chk("reset_rdata", rsp.rsp_rdata, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 32'(cmd_s.ready), 32'd1);
    @(posedge clk); #1;

    rsp_m.rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) issue(1'b0, BASE + 32'(4*i), $urandom, 4'hF, w);
    drain();

    issue(1'b0, BASE + 32'd8, 32'hDEAD_BEEF, 4'hF, w);
    issue(1'b1, BASE + 32'd8, 32'h0, 4'h0, w);
    @(negedge clk);
    chk("read_latency_valid", 32'(rsp.rsp_valid), 32'd1);
    chk("read_after_write", rsp.rsp_rdata, 32'hDEAD_BEEF);
    drain();

    acc = 0;
    for (int i = 0; i < 16; i++) begin
      issue(1'b1, BASE + 32'(4*$urandom_range(0, DEPTH-1)), 32'h0, 4'h0, w);
      acc += w;
    end
    chk("stream_no_stall", 32'(acc), 32'd0);
    drain();

    rsp_m.rsp_ready = 1'b0;
    acc = 0;
    cmd = '{valid: 1'b1, addr: BASE + 32'd12, read: 1'b1, wdata: 32'h0, wmask: 4'h0,
            size: ICB_SIZE_WORD};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cmd_s.ready) begin
        exp_q.push_back(model_step(1'b1, BASE + 32'd12, 32'h0, 4'h0));
        acc++;
      end
      @(posedge clk); #1;
    end
    cmd.valid = 1'b0;
    chk("backpressure_accepted", 32'(acc), 32'(RSP_DEPTH));
    @(negedge clk);
    chk("backpressure_ready_low", 32'(cmd_s.ready), 32'd0);
    chk("backpressure_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 rsp_m.rsp_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("ready_reasserts", 32'(cmd_s.ready), 32'd1);
    @(posedge clk); #1;

    issue(1'b1, BASE + 32'(4*DEPTH), 32'h0, 4'h0, w);
    issue(1'b0, BASE + 32'(4*DEPTH), 32'h5555_AAAA, 4'hF, w);
    issue(1'b1, BASE + 32'(4*(DEPTH-1)), 32'h0, 4'h0, w);
    issue(1'b0, BASE - 32'd4, 32'h7777_8888, 4'hF, w);
    issue(1'b1, BASE - 32'd4, 32'h0, 4'h0, w);
    issue(1'b1, BASE, 32'h0, 4'h0, w);
    issue(1'b1, BASE + 32'd11, 32'h0, 4'h0, w);
    drain();

    issue(1'b0, BASE + 32'd20, 32'h1122_3344, 4'hF, w);
    issue(1'b0, BASE + 32'd20, 32'hAABB_CCDD, 4'b0101, w);
    issue(1'b1, BASE + 32'd20, 32'h0, 4'h0, w);
    issue(1'b0, BASE + 32'd20, 32'h9999_9999, 4'b0000, w);
    issue(1'b1, BASE + 32'd20, 32'h0, 4'h0, w);
    drain();

    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 16 == 0) a = BASE + 32'(4*DEPTH) + 32'($urandom % 64);
      else a = BASE + 32'(4*$urandom_range(0, DEPTH-1)) + 32'($urandom % 4);
      issue(1'($urandom % 2), a, $urandom, 4'($urandom), w);
    end
    rand_rdy = 0;
    @(posedge clk); #2 rsp_m.rsp_ready = 1'b1;
    drain();

    rsp_m.rsp_ready = 1'b0;
    issue(1'b1, BASE + 32'd8, 32'h0, 4'h0, w);
    issue(1'b1, BASE + 32'd16, 32'h0, 4'h0, w);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_forces_ready_low", 32'(cmd_s.ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_clears_rsp_valid", 32'(rsp.rsp_valid), 32'd0);
    chk("rst_clears_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_s.ready), 32'd1);
    chk("no_rsp_after_rst", 32'(rsp.rsp_valid), 32'd0);
    @(posedge clk); #1 rsp_m.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    issue(1'b1, BASE + 32'd8, 32'h0, 4'h0, w);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
